// File: rtl/nios_mem_streamer_pkg.sv
// Shared types and defaults for the on-chip RAM read streamer.
// MEM_STREAMER_FILL_EN (see top) enables the extra FILL state.
package nios_mem_streamer_pkg;

    localparam int DEF_ADDR_W     = 11;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic [3:0] MEM_BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FILL  = 2'd3
    } state_e;

endpackage

// File: rtl/nios_mem_streamer_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output.
// The head reads as zero while empty so stale entries never leak out.
module nios_mem_streamer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + (PW+1)'(1);
        else if (do_pop && !do_push)
            count_d = count_q - (PW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/nios_onchip_mem_streamer.sv
// Avalon-MM read master streaming a contiguous RAM range onto valid/ready.
// Define MEM_STREAMER_FILL_EN to add fill_mode/fill_value and the FILL state.
module nios_onchip_mem_streamer
    import nios_mem_streamer_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
`ifdef MEM_STREAMER_FILL_EN
    input  logic                fill_mode,
    input  logic [DATA_W-1:0]   fill_value,
`endif
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [3:0]          mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic [DATA_W-1:0]   src_data,
    output logic                src_valid,
    input  logic                src_ready,
    output logic                src_last
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     off_q, off_d;
    logic                infl_q, infl_d;
    logic                infl_last_q, infl_last_d;
    logic                done_q, done_d;
`ifdef MEM_STREAMER_FILL_EN
    logic [DATA_W-1:0]   fill_q, fill_d;
`endif

    logic [CW-1:0]       fifo_count;
    logic                fifo_full, fifo_empty;
    logic [DATA_W:0]     fifo_head;
    logic [CW:0]         occupancy;
    logic                issue, last_off, xfer;

    // Occupancy counts the read still in the RAM pipe so its return always has a slot.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, infl_q};
    assign last_off  = (off_q == cnt_q - (ADDR_W+1)'(1));
    assign issue     = (state_q == ST_ISSUE) && !fifo_full && (occupancy < DEPTH_C);
    assign xfer      = src_valid && src_ready;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        infl_d      = issue;
        infl_last_d = issue && last_off;
        done_d      = 1'b0;
`ifdef MEM_STREAMER_FILL_EN
        fill_d      = fill_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        base_d = base_addr;
                        cnt_d  = word_count;
                        off_d  = '0;
`ifdef MEM_STREAMER_FILL_EN
                        fill_d  = fill_value;
                        state_d = fill_mode ? ST_FILL : ST_ISSUE;
`else
                        state_d = ST_ISSUE;
`endif
                    end
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    off_d = off_q + (ADDR_W+1)'(1);
                    if (last_off) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last-flagged word is always the final FIFO entry of the command.
                if (xfer && src_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef MEM_STREAMER_FILL_EN
            ST_FILL: begin
                off_d = off_q + (ADDR_W+1)'(1);
                if (last_off) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            cnt_q       <= '0;
            off_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_STREAMER_FILL_EN
            fill_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
`ifdef MEM_STREAMER_FILL_EN
            fill_q      <= fill_d;
`endif
        end
    end

    nios_mem_streamer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (infl_q),
        .din_i   ({infl_last_q, mem_readdata}),
        .pop_i   (xfer),
        .dout_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign src_valid = !fifo_empty;
    assign src_data  = fifo_head[DATA_W-1:0];
    assign src_last  = fifo_head[DATA_W];

    // Address wraps naturally at 2^ADDR_W by truncation.
    assign mem_address    = base_q + off_q[ADDR_W-1:0];
    assign mem_byteenable = MEM_BE_ALL;
    assign mem_clken      = 1'b1;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;

`ifdef MEM_STREAMER_FILL_EN
    assign mem_chipselect = issue || (state_q == ST_FILL);
    assign mem_write      = (state_q == ST_FILL);
    assign mem_writedata  = fill_q;
`else
    assign mem_chipselect = issue;
    assign mem_write      = 1'b0;
    assign mem_writedata  = '0;
`endif

endmodule

// File: tb/tb_nios_onchip_mem_streamer.sv
// Randomized bench for nios_onchip_mem_streamer with a RAM model and stream scoreboard.
module tb_nios_onchip_mem_streamer;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int FD = 4;
    localparam int NW = 2048;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
`ifdef MEM_STREAMER_FILL_EN
    logic          fill_mode = 1'b0;
    logic [DW-1:0] fill_value = '0;
`endif
    logic          busy, done;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [3:0]    mem_byteenable;
    logic [DW-1:0] mem_writedata, mem_readdata, src_data;
    logic          src_valid, src_last;
    logic          src_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios_onchip_mem_streamer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
`ifdef MEM_STREAMER_FILL_EN
        .fill_mode      (fill_mode),
        .fill_value     (fill_value),
`endif
        .busy           (busy),
        .done           (done),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .src_data       (src_data),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_last       (src_last)
    );

    function automatic logic [DW-1:0] pat(int a);
        if (a >= 16 && a < 20) return DW'(a - 15);
        return (32'h9E37_79B9 * 32'(a + 1)) ^ 32'h5A5A_0F0F;
    endfunction

    // RAM model: registered read, one-cycle latency; contents loaded on first edge.
    logic [DW-1:0] ram [NW];
    logic [DW-1:0] rdata_q = '0;
    logic          init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < NW; i++) ram[i] <= pat(i);
            init_done <= 1'b1;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) ram[mem_address] <= mem_writedata;
            else           rdata_q <= ram[mem_address];
        end
    end
    assign mem_readdata = rdata_q;

    // Expected RAM contents, maintained from the command semantics only.
    logic [DW-1:0] ref_mem [NW];

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_ctl"}, {busy, done, mem_chipselect, mem_write, src_valid, src_last}, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_data"}, {mem_writedata, src_data}, 0);
        chk({tag, "_const"}, {mem_byteenable, mem_clken}, 5'h1F);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: ready low in cycles 4..9, 2: random ready.
    task automatic run_cmd(input int base, input int n, input int mode);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] e;
        logic          hold_pend;
        logic [DW+1:0] held;
        int nissue, nxfer, ndone, done_c, first_v, last_c, over, wr_bad, c;
        nissue = 0; nxfer = 0; ndone = 0; done_c = -1; first_v = -1;
        last_c = -1; over = 0; wr_bad = 0; hold_pend = 1'b0; held = '0;
        for (int k = 0; k < n; k++) exp_q.push_back(ref_mem[(base + k) % NW]);
        start = 1'b1;
        base_addr = AW'(base);
        word_count = (AW+1)'(n);
`ifdef MEM_STREAMER_FILL_EN
        fill_mode = 1'b0;
`endif
        step();
        start = 1'b0;
        for (c = 1; c < n * 4 + 60 && !(done_c >= 0 && c > done_c + 3); c++) begin
            case (mode)
                0:       src_ready = 1'b1;
                1:       src_ready = !(c >= 4 && c <= 9);
                default: src_ready = ($urandom % 3) != 0;
            endcase
            if (c == 1) chk("busy_c1", busy, 1);
            if (hold_pend) chk("hold", {src_valid, src_last, src_data}, held);
            if (mem_chipselect) begin
                chk("rd_addr", mem_address, (base + nissue) % NW);
                if (mem_write) wr_bad++;
                nissue++;
                if (nissue - nxfer > FD) over++;
            end
            if (src_valid && first_v < 0) first_v = c;
            if (src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", src_data, e);
                    chk("last", src_last, exp_q.size() == 0);
                end
                nxfer++;
                if (src_last) last_c = c;
            end
            if (done) begin
                ndone++;
                if (done_c < 0) begin
                    done_c = c;
                    chk("busy_at_done", busy, 0);
                end
            end
            hold_pend = src_valid && !src_ready;
            held = {src_valid, src_last, src_data};
            step();
        end
        chk("timeout", done_c < 0, 0);
        chk("reads", nissue, n);
        chk("xfers", nxfer, n);
        chk("dones", ndone, 1);
        chk("overfill", over, 0);
        chk("write_in_read", wr_bad, 0);
        if (mode == 0) begin
            chk("first_valid_cyc", first_v, 3);
            chk("last_xfer_cyc", last_c, n + 2);
            chk("done_cyc", done_c, n + 3);
        end
        src_ready = 1'b0;
    endtask

    task automatic run_zero;
        int ndone, done_c, ncs, nv, nb;
        ndone = 0; done_c = -1; ncs = 0; nv = 0; nb = 0;
        start = 1'b1;
        base_addr = AW'($urandom_range(NW - 1, 0));
        word_count = '0;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (done) begin ndone++; if (done_c < 0) done_c = c; end
            if (mem_chipselect) ncs++;
            if (src_valid) nv++;
            if (busy) nb++;
            step();
        end
        chk("zero_done_cyc", done_c, 1);
        chk("zero_dones", ndone, 1);
        chk("zero_cs", ncs, 0);
        chk("zero_valid", nv, 0);
        chk("zero_busy", nb, 0);
    endtask

    task automatic run_reset_mid;
        int bad;
        bad = 0;
        start = 1'b1;
        base_addr = AW'($urandom_range(NW - 1, 0));
        word_count = 12'd16;
        src_ready = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        #1;
        chk_rst("rst_mid");
        step();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (done || src_valid || mem_chipselect || busy) bad++;
            step();
        end
        chk("rst_mid_quiet", bad, 0);
        src_ready = 1'b0;
    endtask

`ifdef MEM_STREAMER_FILL_EN
    task automatic run_fill(input int base, input int n, input logic [DW-1:0] v);
        int nw, lw, nd, dc, nv;
        nw = 0; lw = -1; nd = 0; dc = -1; nv = 0;
        start = 1'b1;
        fill_mode = 1'b1;
        fill_value = v;
        base_addr = AW'(base);
        word_count = (AW+1)'(n);
        step();
        start = 1'b0;
        fill_mode = 1'b0;
        for (int c = 1; c <= n + 5; c++) begin
            if (mem_chipselect) begin
                chk("fill_addr", mem_address, (base + nw) % NW);
                chk("fill_we", mem_write, 1);
                chk("fill_wd", mem_writedata, v);
                nw++;
                lw = c;
            end
            if (done) begin nd++; if (dc < 0) dc = c; end
            if (src_valid) nv++;
            step();
        end
        chk("fill_writes", nw, n);
        chk("fill_last_cyc", lw, n);
        chk("fill_done_cyc", dc, n + 1);
        chk("fill_dones", nd, 1);
        chk("fill_no_stream", nv, 0);
        for (int k = 0; k < n; k++) ref_mem[(base + k) % NW] = v;
    endtask
`endif

    initial begin
        for (int i = 0; i < NW; i++) ref_mem[i] = pat(i);
        repeat (3) @(posedge clk);
        #1;
        chk_rst("rst_init");
        reset = 1'b0;
        step();

        run_cmd(16, 4, 0);
        run_cmd(16, 4, 1);
        run_cmd(12'h7FE, 4, 0);
        run_zero();
        run_reset_mid();
        run_cmd($urandom_range(NW - 1, 0), 2, 0);
`ifdef MEM_STREAMER_FILL_EN
        run_fill(12'h100, 8, 32'hA5A5_A5A5);
        run_cmd(12'h100, 8, 0);
`endif
        repeat (3) run_cmd($urandom_range(NW - 1, 0), $urandom_range(20, 1), 0);
        repeat (6) run_cmd($urandom_range(NW - 1, 0), $urandom_range(40, 1), 2);
        run_cmd($urandom_range(NW - 1, 0), 1, 2);
        run_cmd($urandom_range(NW - 1, 0), NW, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
